// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_sram_slave
//  Description : AHB-Lite slave backed by a word-addressed SRAM. The low
//                RO_LIMIT words are read-only. NONSEQ transfers get
//                WAIT_STATES wait cycles. Bad transfers get a two-cycle ERROR.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_sram_slave #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int RO_LIMIT      = 16,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [ADDRESS_WIDTH-1:0] HADDR,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [1:0]               HTRANS,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic                     HREADY,
    output logic                     HRESP
);

    localparam int                       c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] c_DEPTH     = ADDRESS_WIDTH'(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_RO_LIMIT  = ADDRESS_WIDTH'(RO_LIMIT);
    localparam logic [3:0]               c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [2:0]               c_SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_hready;
    logic                 r_hresp;
    logic                 r_pend;     // an OKAY data phase is outstanding
    logic                 r_write;
    logic [c_IDX_W-1:0]   r_addr;
    logic [3:0]           r_wcnt;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic w_accept;
    logic w_err;
    logic w_nonseq;
    logic w_data_done;
    logic [2:0] w_unused_hburst;

    // The burst type carries no meaning for this slave; addresses arrive every beat.
    assign w_unused_hburst = HBURST;

    assign w_accept    = r_hready & HTRANS[1];
    assign w_nonseq    = HTRANS[1] & ~HTRANS[0];
    assign w_err       = (HSIZE != c_SIZE_WORD) || (HADDR >= c_DEPTH) ||
                         (HWRITE && (HADDR < c_RO_LIMIT));
    // An OKAY data phase finishes in any cycle where HREADY is high and one is pending.
    assign w_data_done = r_hready & r_pend;

    // Transfer-response FSM: accepts address phases and drives HREADY/HRESP.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_READY;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_pend   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wcnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_READY, ST_ERR2: begin
                    if (w_accept) begin
                        r_addr  <= HADDR[c_IDX_W-1:0];
                        r_write <= HWRITE;
                        if (w_err) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                            r_pend   <= 1'b0;
                        end else if (w_nonseq && (WAIT_STATES > 0)) begin
                            r_state  <= ST_WAIT;
                            r_wcnt   <= c_WAIT_LOAD;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                            r_pend   <= 1'b1;
                        end else begin
                            r_state  <= ST_READY;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                            r_pend   <= 1'b1;
                        end
                    end else begin
                        // IDLE/BUSY or no new transfer: next cycle is a plain zero-wait OKAY.
                        r_state  <= ST_READY;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                        r_pend   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state  <= ST_READY;
                        r_hready <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    r_state  <= ST_READY;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                    r_pend   <= 1'b0;
                end
            endcase
        end
    end

    // Write commit at the edge that closes an OKAY write data phase; memory is never reset.
    always_ff @(posedge HCLK) begin
        if (w_data_done && r_write) begin
            r_mem[r_addr] <= HWDATA;
        end
    end

    assign HRDATA = (w_data_done && !r_write) ? r_mem[r_addr] : '0;
    assign HREADY = r_hready;
    assign HRESP  = r_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_sram_slave
//  Description : Self-checking bench for ahb_lite_sram_slave. Two instances
//                (0 and 2 wait states) share one pipelined bus master; a
//                behavioural memory/response model predicts every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_sram_slave;

    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_BUSY   = 2'b01;
    localparam logic [1:0] c_NONSEQ = 2'b10;
    localparam logic [1:0] c_SEQ    = 2'b11;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          chk;
        bit          chk_data;
        bit          exp_resp;
        logic [31:0] exp_rdata;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;

    logic [1:0]  trans0, trans1;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, resp0, resp1;
    logic [31:0] w_rdata;
    logic        w_rdy, w_resp;

    assign trans0  = sel ? c_IDLE : htrans;
    assign trans1  = sel ? htrans : c_IDLE;
    assign w_rdata = sel ? rdata1 : rdata0;
    assign w_rdy   = sel ? rdy1 : rdy0;
    assign w_resp  = sel ? resp1 : resp0;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HTRANS(trans0), .HWDATA(hwdata),
        .HRDATA(rdata0), .HREADY(rdy0), .HRESP(resp0)
    );

    ahb_lite_sram_slave #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HTRANS(trans1), .HWDATA(hwdata),
        .HRDATA(rdata1), .HREADY(rdy1), .HRESP(resp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory per instance; kn marks words whose content the model knows.
    logic [31:0] mm [2][256];
    bit          kn [2][256];
    beat_t       q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic beat_t mk(logic [1:0] t, int a, logic w, logic [2:0] sz, logic [31:0] d,
                                 bit c, bit cd, bit er, logic [31:0] ed);
        beat_t b;
        b.trans = t; b.addr = 32'(a); b.write = w; b.size = sz; b.wdata = d;
        b.chk = c; b.chk_data = cd; b.exp_resp = er; b.exp_rdata = ed;
        return b;
    endfunction

    // Drives the queued beats as a pipelined master and checks every cycle.
    task automatic run_beats(input string tag);
        int          idx;
        bit          pend;
        beat_t       pb;
        int          k;
        int          w;
        bit          perr;
        bit          e_rdy;
        bit          e_resp;
        logic [31:0] e_data;
        bit          rdy_s;
        int          s;
        idx = 0; pend = 0; k = 0; w = 0; perr = 0;
        s = sel ? 1 : 0;
        while (idx < q.size() || pend) begin
            if (idx < q.size()) begin
                htrans = q[idx].trans; haddr = q[idx].addr;
                hwrite = q[idx].write; hsize = q[idx].size;
            end else begin
                htrans = c_IDLE;
            end
            hwdata = pend ? pb.wdata : 32'h0;
            @(negedge clk);
            e_data = 32'h0;
            if (!pend) begin
                e_rdy = 1'b1; e_resp = 1'b0;
            end else if (perr) begin
                e_rdy = (k == 1); e_resp = 1'b1;
            end else begin
                e_rdy = (k == w); e_resp = 1'b0;
                if (e_rdy && !pb.write) begin
                    if (!kn[s][pb.addr[7:0]]) begin
                        // never-written word: its content is whatever the array powered up with
                        mm[s][pb.addr[7:0]] = w_rdata;
                        kn[s][pb.addr[7:0]] = 1'b1;
                    end
                    e_data = mm[s][pb.addr[7:0]];
                end
            end
            checks++;
            if ({w_rdy, w_resp, w_rdata} !== {e_rdy, e_resp, e_data}) begin
                errors++;
                $display("FAIL %s cycle: got rdy=%0b resp=%0b rdata=%h, want rdy=%0b resp=%0b rdata=%h",
                         tag, w_rdy, w_resp, w_rdata, e_rdy, e_resp, e_data);
            end
            if (pend && e_rdy && pb.chk) begin
                checks++;
                if (w_resp !== pb.exp_resp || (pb.chk_data && w_rdata !== pb.exp_rdata)) begin
                    errors++;
                    $display("FAIL %s addr %0d: got resp=%0b rdata=%h, want resp=%0b rdata=%h",
                             tag, pb.addr, w_resp, w_rdata, pb.exp_resp, pb.exp_rdata);
                end
            end
            rdy_s = w_rdy;
            @(posedge clk); #1;
            if (rdy_s) begin
                if (pend && !perr && pb.write) begin
                    mm[s][pb.addr[7:0]] = pb.wdata;
                    kn[s][pb.addr[7:0]] = 1'b1;
                end
                pend = 0;
                if (idx < q.size()) begin
                    if (q[idx].trans[1]) begin
                        pb   = q[idx];
                        pend = 1; k = 0;
                        perr = (pb.size != 3'b010) || (pb.addr >= 256) || (pb.write && pb.addr < 16);
                        w    = (pb.trans == c_NONSEQ) ? (s * 2) : 0;
                    end
                    idx++;
                end
            end else begin
                k++;
                if (k > 40) begin
                    errors++;
                    $display("FAIL %s timeout: HREADY stuck low, got %0b want 1", tag, w_rdy);
                    break;
                end
            end
        end
        htrans = c_IDLE;
        q.delete();
    endtask

    task automatic gen_random(int n);
        beat_t b;
        int    r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            b.trans  = (r < 4) ? c_NONSEQ : (r < 7) ? c_SEQ : (r < 8) ? c_BUSY : c_IDLE;
            b.addr   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300))
                                                   : 32'($urandom_range(0, 255));
            b.write  = 1'($urandom_range(0, 1));
            b.size   = ($urandom_range(0, 15) == 0) ? 3'b001 : 3'b010;
            b.wdata  = $urandom;
            b.chk = 0; b.chk_data = 0; b.exp_resp = 0; b.exp_rdata = 32'h0;
            q.push_back(b);
        end
    endtask

    beat_t tbl [12];

    initial begin
        tbl[0]  = mk(c_NONSEQ, 20,  1, 3'b010, 32'hDEADBEEF, 1, 0, 0, 32'h0);
        tbl[1]  = mk(c_NONSEQ, 20,  0, 3'b010, 32'h0,        1, 1, 0, 32'hDEADBEEF);
        tbl[2]  = mk(c_NONSEQ, 5,   0, 3'b010, 32'h0,        1, 0, 0, 32'h0);
        tbl[3]  = mk(c_NONSEQ, 5,   1, 3'b010, 32'h12345678, 1, 1, 1, 32'h0);
        tbl[4]  = mk(c_NONSEQ, 5,   0, 3'b010, 32'h0,        1, 0, 0, 32'h0);
        tbl[5]  = mk(c_NONSEQ, 300, 0, 3'b010, 32'h0,        1, 1, 1, 32'h0);
        tbl[6]  = mk(c_NONSEQ, 30,  0, 3'b001, 32'h0,        1, 1, 1, 32'h0);
        tbl[7]  = mk(c_NONSEQ, 255, 1, 3'b010, 32'hCAFE00FF, 1, 0, 0, 32'h0);
        tbl[8]  = mk(c_NONSEQ, 255, 0, 3'b010, 32'h0,        1, 1, 0, 32'hCAFE00FF);
        tbl[9]  = mk(c_NONSEQ, 256, 1, 3'b010, 32'h11111111, 1, 1, 1, 32'h0);
        tbl[10] = mk(c_NONSEQ, 16,  1, 3'b010, 32'h00000016, 1, 0, 0, 32'h0);
        tbl[11] = mk(c_NONSEQ, 15,  1, 3'b010, 32'h00000015, 1, 1, 1, 32'h0);

        rst_n = 1'b0; sel = 1'b0; htrans = c_IDLE; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b001; hwdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdy0, resp0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset0: got rdy=%0b resp=%0b rdata=%h, want 1 0 0", rdy0, resp0, rdata0);
        end
        checks++;
        if ({rdy1, resp1, rdata1} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset2: got rdy=%0b resp=%0b rdata=%h, want 1 0 0", rdy1, resp1, rdata1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors on the zero-wait instance, one transfer at a time.
        for (int i = 0; i < 12; i++) begin
            q.push_back(tbl[i]);
            run_beats($sformatf("vec%0d", i));
        end

        // Pipelined write then read of the same word.
        q.push_back(mk(c_NONSEQ, 70, 1, 3'b010, 32'h7070A5A5, 0, 0, 0, 32'h0));
        q.push_back(mk(c_NONSEQ, 70, 0, 3'b010, 32'h0,        1, 1, 0, 32'h7070A5A5));
        run_beats("b2b_wr_rd");

        // Two-wait-state instance: NONSEQ waits, following SEQ beats do not.
        sel = 1'b1;
        q.push_back(mk(c_NONSEQ, 40, 1, 3'b010, 32'h40404040, 0, 0, 0, 32'h0));
        q.push_back(mk(c_SEQ,    41, 1, 3'b010, 32'h41414141, 0, 0, 0, 32'h0));
        q.push_back(mk(c_SEQ,    42, 1, 3'b010, 32'h42424242, 0, 0, 0, 32'h0));
        q.push_back(mk(c_NONSEQ, 40, 0, 3'b010, 32'h0, 1, 1, 0, 32'h40404040));
        q.push_back(mk(c_SEQ,    41, 0, 3'b010, 32'h0, 1, 1, 0, 32'h41414141));
        q.push_back(mk(c_SEQ,    42, 0, 3'b010, 32'h0, 1, 1, 0, 32'h42424242));
        run_beats("ws2_burst");

        // INCR4 write with a BUSY after the second beat, then read back.
        hburst = 3'b011;
        q.push_back(mk(c_NONSEQ, 50, 1, 3'b010, 32'd1, 0, 0, 0, 32'h0));
        q.push_back(mk(c_SEQ,    51, 1, 3'b010, 32'd2, 0, 0, 0, 32'h0));
        q.push_back(mk(c_BUSY,   52, 1, 3'b010, 32'd0, 0, 0, 0, 32'h0));
        q.push_back(mk(c_SEQ,    52, 1, 3'b010, 32'd3, 0, 0, 0, 32'h0));
        q.push_back(mk(c_SEQ,    53, 1, 3'b010, 32'd4, 0, 0, 0, 32'h0));
        q.push_back(mk(c_NONSEQ, 50, 0, 3'b010, 32'h0, 1, 1, 0, 32'd1));
        q.push_back(mk(c_SEQ,    51, 0, 3'b010, 32'h0, 1, 1, 0, 32'd2));
        q.push_back(mk(c_SEQ,    52, 0, 3'b010, 32'h0, 1, 1, 0, 32'd3));
        q.push_back(mk(c_SEQ,    53, 0, 3'b010, 32'h0, 1, 1, 0, 32'd4));
        run_beats("incr4_busy");
        hburst = 3'b001;

        // Randomized traffic on both instances.
        sel = 1'b0;
        gen_random(250);
        run_beats("rand_ws0");
        sel = 1'b1;
        gen_random(250);
        run_beats("rand_ws2");

        // Reset during the wait phase of a write must abandon it.
        q.push_back(mk(c_NONSEQ, 60, 1, 3'b010, 32'h600D0060, 0, 0, 0, 32'h0));
        run_beats("pre_rst_wr");
        htrans = c_NONSEQ; haddr = 32'd60; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        htrans = c_IDLE; hwdata = 32'hBAD0BAD0;
        @(negedge clk);
        checks++;
        if (w_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: got rdy=%0b, want 0", w_rdy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({w_rdy, w_resp, w_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_async: got rdy=%0b resp=%0b rdata=%h, want 1 0 0", w_rdy, w_resp, w_rdata);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.push_back(mk(c_NONSEQ, 60, 0, 3'b010, 32'h0, 1, 1, 0, 32'h600D0060));
        run_beats("post_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave: word-addressed SRAM with a read-only low region, programmable wait states on NONSEQ transfers, and two-cycle ERROR responses.
- Responder end of the master-side bus tasks (single read/write, 4/8/16-beat bursts, BUSY insertion); binds to the Slave modport of AHBInterface.
- Serves as the DUT memory model for the AHB-Lite verification environment.

Parameters:
- ADDRESS_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width.
- MEM_DEPTH, 256, number of DATA_WIDTH words; valid addresses 0..MEM_DEPTH-1.
- RO_LIMIT, 16, addresses below RO_LIMIT are read-only.
- WAIT_STATES, 0, HREADY-low cycles inserted before a NONSEQ data phase completes (0..15).

Ports:
- HCLK  input  1  bus clock; all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HADDR  input  ADDRESS_WIDTH  word address (address increments by 1 per beat).
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  transfer size; only 3'b010 (word) supported.
- HBURST  input  3  burst type; recorded only, not checked.
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWDATA  input  DATA_WIDTH  write data, valid in the data phase.
- HRDATA  output  DATA_WIDTH  read data.
- HREADY  output  1  transfer done / slave ready; also the bus HREADY the slave samples.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, HRESETn=0): state=READY, HREADY=1, HRESP=0, HRDATA=0, wait counter=0, pending phase cleared.
  - Memory array is not reset; contents survive reset.
  - A reset mid-transfer abandons the transfer: no write is committed and no response is given.
- Address phase accepted on a rising edge with HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ).
  - Registers addr_q, write_q and the check result.
  - IDLE/BUSY with HREADY=1: nothing registered; next cycle returns zero-wait OKAY.
- Error check at acceptance: ERROR if HSIZE!=3'b010, if HADDR>=MEM_DEPTH, or if (HWRITE=1 and HADDR<RO_LIMIT).
- FSM states: READY, WAIT, ERR1, ERR2.
  - READY: HREADY=1, HRESP=0.
    - Accepted error transfer -> ERR1.
    - Accepted NONSEQ with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES-1.
    - Otherwise stay.
  - WAIT: HREADY=0, HRESP=0. counter==0 -> READY (data phase completes there); else counter decrements.
  - ERR1: HREADY=0, HRESP=1; -> ERR2.
  - ERR2: HREADY=1, HRESP=1; address phase may be accepted here (same rules as READY).
- SEQ transfers always complete zero-wait.
- Latency for an OKAY transfer: 1 + WAIT_STATES cycles after NONSEQ acceptance; 1 cycle after SEQ acceptance.
- Write commit: mem[addr_q] <= HWDATA on the rising edge ending the data phase (HREADY=1, OKAY). Erroring writes never modify memory.
- Read data:
  - HRDATA = mem[addr_q] combinationally while a read data phase has HREADY=1 and OKAY; otherwise HRDATA=0.
  - Back-to-back write then read of the same address returns the newly written data (write commits before the read data phase).
- Bursts:
  - Pipelined: a new address phase is accepted in the same cycle a data phase completes.
  - BUSY beats do not terminate the burst and produce no memory access.
  - The address is taken from HADDR each beat; the slave does not compute it.
- Wrap: none; any address >= MEM_DEPTH gets ERROR.

Test Plan:
- Write 32'hDEADBEEF to addr 20, then read addr 20, WAIT_STATES=0 -> each data phase completes in 1 cycle; HRDATA=32'hDEADBEEF; HRESP=0.
- WAIT_STATES=2, NONSEQ read of addr 40 -> HREADY low for exactly 2 cycles, then high with correct data; SEQ beats that follow complete zero-wait.
- 4-beat INCR4 write to 50..53 with data 1,2,3,4 and one BUSY after beat 2, then 4-beat read -> reads return 1,2,3,4; BUSY cycle gives HREADY=1, HRESP=0 with no access.
- Write 32'h12345678 to addr 5 (below RO_LIMIT) -> HREADY=0/HRESP=1 then HREADY=1/HRESP=1; mem[5] unchanged on read-back.
- Read addr 300 and read addr 30 with HSIZE=3'b001 -> both give a two-cycle ERROR response with HRDATA=0.
- Assert HRESETn during a WAIT state of a write to addr 60 -> outputs go immediately to HREADY=1, HRESP=0, HRDATA=0; mem[60] keeps its prior value.
